// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two-requester register-file writeback arbiter with scoreboard.
//
// Requesters A (ALU writeback) and B (load / long-latency writeback) compete
// for a single register-file write port. Contention is resolved round-robin.
// The winner's write appears on regWrite/wR/writeData one cycle after the
// transfer. A 2**ADDR_W-entry scoreboard tracks registers with an issued but
// not yet written result.
//
// Ports:
//   clk, reset (async, active-low)
//   a_valid/a_addr/a_data -> a_ready   requester A write request / accept
//   b_valid/b_addr/b_data -> b_ready   requester B write request / accept
//   regWrite/wR/writeData              registered register-file write port
//   iss_valid/iss_rd                   instruction issue (sets pending[iss_rd])
//   rs1/rs2 -> rs1_busy/rs2_busy       source hazard lookup (combinational)
//   pending                            scoreboard bit vector
//
// Optional feature, macro WB_FORWARD_EN: adds fwd1_hit, fwd2_hit, fwd_data.
// When a source matches the write in flight, its busy flag is suppressed.
module wb_port_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_valid,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     b_ready,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        wR,
    output logic [DATA_W-1:0]        writeData,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_rd,
    input  logic [ADDR_W-1:0]        rs1,
    input  logic [ADDR_W-1:0]        rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
`ifdef WB_FORWARD_EN
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [DATA_W-1:0]        fwd_data,
`endif
    output logic [(2**ADDR_W)-1:0]   pending
);

    localparam int unsigned NREG = 2**ADDR_W;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e              r_last_grant;
    logic                r_regWrite;
    logic [ADDR_W-1:0]   r_wR;
    logic [DATA_W-1:0]   r_writeData;
    logic [NREG-1:0]     r_pending;

    logic                w_a_ready;
    logic                w_b_ready;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [NREG-1:0]     w_pending_nxt;

    // Round-robin grant; gated by reset so nothing is accepted while in reset.
    always_comb begin
        w_a_ready = reset && a_valid && (!b_valid || (r_last_grant == GRANT_B));
        w_b_ready = reset && b_valid && (!a_valid || (r_last_grant == GRANT_A));
        w_xfer    = w_a_ready || w_b_ready;
        w_addr    = w_a_ready ? a_addr : b_addr;
        w_data    = w_a_ready ? a_data : b_data;
    end

    // Scoreboard next state: clear on write, then set on issue so set wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_regWrite) begin
            w_pending_nxt[r_wR] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            w_pending_nxt[iss_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Grant history, write port and scoreboard registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= GRANT_B;
            r_regWrite   <= 1'b0;
            r_wR         <= '0;
            r_writeData  <= '0;
            r_pending    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_xfer) begin
                r_last_grant <= w_a_ready ? GRANT_A : GRANT_B;
            end
            // Writes to register 0 are accepted but discarded.
            r_regWrite <= w_xfer && (w_addr != '0);
            if (w_xfer && (w_addr != '0)) begin
                r_wR        <= w_addr;
                r_writeData <= w_data;
            end
        end
    end

    assign a_ready   = w_a_ready;
    assign b_ready   = w_b_ready;
    assign regWrite  = r_regWrite;
    assign wR        = r_wR;
    assign writeData = r_writeData;
    assign pending   = r_pending;

`ifdef WB_FORWARD_EN
    // A source matching the write in flight is satisfied by forwarding.
    logic w_fwd1_hit;
    logic w_fwd2_hit;

    always_comb begin
        w_fwd1_hit = r_regWrite && (r_wR == rs1) && (rs1 != '0);
        w_fwd2_hit = r_regWrite && (r_wR == rs2) && (rs2 != '0);
    end

    assign fwd1_hit = w_fwd1_hit;
    assign fwd2_hit = w_fwd2_hit;
    assign fwd_data = r_writeData;
    assign rs1_busy = r_pending[rs1] && !w_fwd1_hit;
    assign rs2_busy = r_pending[rs2] && !w_fwd2_hit;
`else
    assign rs1_busy = r_pending[rs1];
    assign rs2_busy = r_pending[rs2];
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge (registered) or 1 time unit after an input change (combinational).
module tb_wb_port_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 32;

    logic              clk;
    logic              reset;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              regWrite;
    logic [ADDR_W-1:0] wR;
    logic [DATA_W-1:0] writeData;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [NREG-1:0]   pending;
`ifdef WB_FORWARD_EN
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    int n_tests;
    int n_fail;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .regWrite  (regWrite),
        .wR        (wR),
        .writeData (writeData),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
`ifdef WB_FORWARD_EN
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd_data  (fwd_data),
`endif
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one full cycle, ending on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
        #2 reset = 1'b0;
        tick();
        tick();
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        n_tests++;
        if (regWrite !== 1'b0 || wR !== '0 || writeData !== '0) begin
            n_fail++;
            $display("FAIL reset_wport: regWrite=%0b wR=%0d wd=%h, want 0 0 0", regWrite, wR, writeData);
        end
        n_tests++;
        if (pending !== '0) begin
            n_fail++;
            $display("FAIL reset_pending: got %h want 0", pending);
        end
        n_tests++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: a=%0b b=%0b want 0 0", a_ready, b_ready);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        // A alone
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0000_1003;
        #1;
        n_tests++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_a_ready: a=%0b b=%0b want 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        n_tests++;
        if (regWrite !== 1'b1 || wR !== 5'd3 || writeData !== 32'h0000_1003) begin
            n_fail++;
            $display("FAIL single_a_write: rw=%0b wR=%0d wd=%h want 1 3 00001003", regWrite, wR, writeData);
        end
        tick();
        n_tests++;
        if (regWrite !== 1'b0 || wR !== 5'd3 || writeData !== 32'h0000_1003) begin
            n_fail++;
            $display("FAIL single_idle_hold: rw=%0b wR=%0d wd=%h want 0 3 00001003", regWrite, wR, writeData);
        end
        n_tests++;
        if (pending !== '0) begin
            n_fail++;
            $display("FAIL single_nopend: pending=%h want 0", pending);
        end
        // B alone
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h0000_2004;
        #1;
        n_tests++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_b_ready: a=%0b b=%0b want 0 1", a_ready, b_ready);
        end
        tick();
        b_valid = 1'b0;
        n_tests++;
        if (regWrite !== 1'b1 || wR !== 5'd4 || writeData !== 32'h0000_2004) begin
            n_fail++;
            $display("FAIL single_b_write: rw=%0b wR=%0d wd=%h want 1 4 00002004", regWrite, wR, writeData);
        end
        tick();
    endtask

    task automatic test_contention();
        logic exp_a;
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h0000_00A8;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_00B9;
        for (int i = 0; i < 4; i++) begin
            exp_a = ((i % 2) == 0);
            #1;
            n_tests++;
            if (a_ready !== exp_a || b_ready !== !exp_a) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: a=%0b b=%0b want %0b %0b", i, a_ready, b_ready, exp_a, !exp_a);
            end
            tick();
            n_tests++;
            if (regWrite !== 1'b1 || wR !== (exp_a ? 5'd8 : 5'd9)) begin
                n_fail++;
                $display("FAIL contention_wr[%0d]: rw=%0b wR=%0d want 1 %0d", i, regWrite, wR, exp_a ? 8 : 9);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        a_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_addr = ADDR_W'(i);
            a_data = 32'h100 + 32'(i);
            #1;
            n_tests++;
            if (a_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %0b want 1", i, a_ready);
            end
            tick();
            n_tests++;
            if (regWrite !== 1'b1 || wR !== ADDR_W'(i) || writeData !== (32'h100 + 32'(i))) begin
                n_fail++;
                $display("FAIL b2b_write[%0d]: rw=%0b wR=%0d wd=%h want 1 %0d %h", i, regWrite, wR, writeData, i, 32'h100 + 32'(i));
            end
        end
        a_valid = 1'b0;
        tick();
    endtask

    task automatic test_zero_reg();
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_DEAD;
        #1;
        n_tests++;
        if (b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: b_ready=%0b want 1", b_ready);
        end
        tick();
        b_valid = 1'b0;
        n_tests++;
        if (regWrite !== 1'b0 || wR !== 5'd4 || writeData !== 32'h0000_0104) begin
            n_fail++;
            $display("FAIL zero_nowrite: rw=%0b wR=%0d wd=%h want 0 4 00000104", regWrite, wR, writeData);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        iss_valid = 1'b0;
        rs1 = 5'd10;
        #1;
        n_tests++;
        if (rs1_busy !== 1'b1 || pending !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL sb_set: rs1_busy=%0b pending=%h want 1 00000400", rs1_busy, pending);
        end
        // iss_rd=0 must never mark register 0
        iss_valid = 1'b1; iss_rd = 5'd0;
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h0000_0032;
        tick();
        iss_valid = 1'b0;
        a_valid = 1'b0;
        n_tests++;
        if (regWrite !== 1'b1 || wR !== 5'd10 || pending !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL sb_inflight: rw=%0b wR=%0d pending=%h want 1 10 00000400", regWrite, wR, pending);
        end
        tick();
        n_tests++;
        if (pending !== '0 || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clear: pending=%h rs1_busy=%0b want 0 0", pending, rs1_busy);
        end
        rs1 = '0;
    endtask

    task automatic test_collision();
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h0000_0C0C;
        tick();
        a_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd12;
        tick();
        iss_valid = 1'b0;
        n_tests++;
        if (pending !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL collision_setwins: pending=%h want 00001000", pending);
        end
        // retire it so later tests start clean
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h0000_0C0D;
        tick();
        a_valid = 1'b0;
        tick();
        n_tests++;
        if (pending !== '0) begin
            n_fail++;
            $display("FAIL collision_retire: pending=%h want 0", pending);
        end
    endtask

    task automatic test_forward();
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_0064;
        tick();
        a_valid = 1'b0;
        rs2 = 5'd5;
        rs1 = 5'd6;
        #1;
        n_tests++;
        if (regWrite !== 1'b1 || wR !== 5'd5 || pending !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL fwd_setup: rw=%0b wR=%0d pending=%h want 1 5 00000020", regWrite, wR, pending);
        end
`ifdef WB_FORWARD_EN
        n_tests++;
        if (fwd2_hit !== 1'b1 || fwd_data !== 32'h0000_0064 || rs2_busy !== 1'b0 || fwd1_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_hit: fwd2=%0b fd=%h rs2_busy=%0b fwd1=%0b want 1 00000064 0 0", fwd2_hit, fwd_data, rs2_busy, fwd1_hit);
        end
`else
        n_tests++;
        if (rs2_busy !== 1'b1 || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_off_busy: rs2_busy=%0b rs1_busy=%0b want 1 0", rs2_busy, rs1_busy);
        end
`endif
        tick();
        rs1 = '0;
        rs2 = '0;
    endtask

    task automatic test_reset_midstream();
        // Build up state: pending bit and an in-flight write.
        iss_valid = 1'b1; iss_rd = 5'd7;
        a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h0000_0222;
        tick();
        iss_valid = 1'b0;
        a_addr = 5'd3; a_data = 32'h0000_0333;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h0000_0BBB;
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (regWrite !== 1'b0 || pending !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: rw=%0b pending=%h want 0 0", regWrite, pending);
        end
        n_tests++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ready: a=%0b b=%0b want 0 0", a_ready, b_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_grant: a=%0b b=%0b want 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        n_tests++;
        if (regWrite !== 1'b1 || wR !== 5'd3 || writeData !== 32'h0000_0333) begin
            n_fail++;
            $display("FAIL midrst_write: rw=%0b wR=%0d wd=%h want 1 3 00000333", regWrite, wR, writeData);
        end
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_forward();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
